mem_arbiter: RTL

//  Sits directly below cpu_datapath. Merges its two memory ports into one downstream memory port:
//   - port A: instruction fetch, read-only
//   - port B: data load/store

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges an instruction-fetch port (A) and a data port (B)
// onto one downstream memory port, with a saturating contention counter.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_a,
  input  logic              write_a,
  input  logic [MASK_W-1:0] wmask_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              resp_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              read_b,
  input  logic              write_b,
  input  logic [MASK_W-1:0] wmask_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              resp_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 1 = port B was granted last
  logic [CNT_W-1:0] contention_cnt_q, contention_cnt_d;
  logic             req_a, req_b;

  assign req_a = read_a | write_a;
  assign req_b = read_b | write_b;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    contention_cnt_d = contention_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          // conflict goes to whichever port did not win last time
          if (last_grant_q) begin
            state_d      = SERVE_A;
            last_grant_d = 1'b0;
          end else begin
            state_d      = SERVE_B;
            last_grant_d = 1'b1;
          end
        end else if (req_a) begin
          state_d      = SERVE_A;
          last_grant_d = 1'b0;
        end else if (req_b) begin
          state_d      = SERVE_B;
          last_grant_d = 1'b1;
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE) && req_a && req_b && (contention_cnt_q != CNT_MAX))
      contention_cnt_d = contention_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      contention_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  // Downstream and response steering decode only the registered state.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = '0;
    mem_address = '0;
    mem_wdata   = '0;
    resp_a      = 1'b0;
    rdata_a     = '0;
    resp_b      = 1'b0;
    rdata_b     = '0;
    case (state_q)
      SERVE_A: begin
        mem_read    = read_a;
        mem_write   = write_a;
        mem_wmask   = wmask_a;
        mem_address = address_a;
        mem_wdata   = wdata_a;
        resp_a      = mem_resp;
        rdata_a     = mem_rdata;
      end
      SERVE_B: begin
        mem_read    = read_b;
        mem_write   = write_b;
        mem_wmask   = wmask_b;
        mem_address = address_b;
        mem_wdata   = wdata_b;
        resp_b      = mem_resp;
        rdata_b     = mem_rdata;
      end
      default: ;
    endcase
  end

  assign contention_cnt = contention_cnt_q;

endmodule
